serial_hex_loader: RTL

Parametrised UART-to-memory boot loader. Converts a stream of ASCII hex characters from the UART receiver into DATA_W-bit words and writes them to consecutive memory addresses starting at a CPU-programmed base. It sits between the UART RX strobe interface and the PSRAM/memory write port. It exposes a small register window to the CPU, whose bus access stalls (`ready`=0) while a load is in progress.

---
 rtl/serial_hex_loader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/serial_hex_loader.sv
// UART-to-memory boot loader: assembles ASCII hex characters into DATA_W-bit
// words and writes them to consecutive addresses from a CPU-programmed base.
//
// state   | meaning
// IDLE    | waiting for a CTRL start write; CPU accesses complete immediately
// RECV    | collecting hex digits into the word buffer
// WRITE   | holding a completed word on the memory port until mem_ready
module serial_hex_loader #(
  parameter int              DATA_W      = 32,
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_RST  = '0,
  parameter bit              LITTLE_END  = 1'b1,
  parameter bit              ALLOW_UPPER = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        a,
  input  logic [31:0]       d,
  input  logic              we,
  output logic [31:0]       spo,
  output logic              ready,
  output logic              busy,
  input  logic [7:0]        uart_data,
  input  logic              uart_ready,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_d,
  output logic              mem_we,
  input  logic              mem_ready
);

  localparam int NIBS  = DATA_W / 4;
  localparam int NIB_W = $clog2(NIBS + 1);
  localparam logic [DATA_W-1:0] NIB_MASK = {{(DATA_W-4){1'b0}}, 4'hF};
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(DATA_W / 8);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   base, addr;
  logic [ADDR_W-1:0]   base_wr_val;
  logic [31:0]         base_rd;
  logic [31:0]         words;
  logic                overrun, partial;
  logic [NIB_W-1:0]    nib;
  logic [DATA_W-1:0]   word_buf, word_next;
  logic                pend_valid;
  logic [7:0]          pend_data;

  logic                start;
  logic                chr_valid;
  logic [7:0]          chr;
  logic                digit_ok;
  logic [3:0]          digit_val;
  logic                word_full;
  int                  pos;

  // BASE is ADDR_W bits wide but the CPU window is 32 bits.
  generate
    if (ADDR_W == 32) begin : g_base32
      assign base_wr_val = d;
      assign base_rd     = base;
    end else if (ADDR_W < 32) begin : g_base_narrow
      assign base_wr_val = d[ADDR_W-1:0];
      assign base_rd     = {{(32-ADDR_W){1'b0}}, base};
    end else begin : g_base_wide
      assign base_wr_val = {{(ADDR_W-32){1'b0}}, d};
      assign base_rd     = base[31:0];
    end
  endgenerate

  assign busy   = (state != S_IDLE);
  assign ready  = ~busy;
  assign mem_we = (state == S_WRITE);
  assign start  = (state == S_IDLE) && we && (a == 3'd1) && d[0];

  // The pending character always goes first; a live strobe then waits in the buffer.
  assign chr_valid = (state == S_RECV) && (pend_valid || uart_ready);
  assign chr       = pend_valid ? pend_data : uart_data;
  assign word_full = (nib == NIB_W'(NIBS - 1));

  always_comb begin
    digit_ok  = 1'b0;
    digit_val = 4'h0;
    if (chr >= 8'h30 && chr <= 8'h39) begin
      digit_ok  = 1'b1;
      digit_val = chr[3:0];
    end else if (chr >= 8'h61 && chr <= 8'h66) begin
      digit_ok  = 1'b1;
      digit_val = chr[3:0] + 4'd9;
    end else if (ALLOW_UPPER && chr >= 8'h41 && chr <= 8'h46) begin
      digit_ok  = 1'b1;
      digit_val = chr[3:0] + 4'd9;
    end
  end

  // Little-endian: byte nib/2, high nibble first. Big-endian: MSB first.
  always_comb begin
    pos = 0;
    if (LITTLE_END)
      pos = (int'(nib) >> 1) * 8 + (nib[0] ? 0 : 4);
    else
      pos = DATA_W - 4 - 4 * int'(nib);
    word_next = (word_buf & ~(NIB_MASK << pos)) |
                ({{(DATA_W-4){1'b0}}, digit_val} << pos);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RECV;
      S_RECV: begin
        if (chr_valid) begin
          if (!digit_ok)
            state_nxt = S_IDLE;
          else if (word_full)
            state_nxt = S_WRITE;
        end
      end
      S_WRITE: if (mem_ready) state_nxt = S_RECV;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      base       <= BASE_RST;
      addr       <= '0;
      words      <= '0;
      overrun    <= 1'b0;
      partial    <= 1'b0;
      nib        <= '0;
      word_buf   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      mem_a      <= '0;
      mem_d      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (we && a == 3'd0)
            base <= base_wr_val;
          if (start) begin
            addr       <= base;
            words      <= '0;
            nib        <= '0;
            overrun    <= 1'b0;
            partial    <= 1'b0;
            word_buf   <= '0;
            pend_valid <= 1'b0;
          end
        end
        S_RECV: begin
          if (chr_valid) begin
            if (digit_ok) begin
              if (word_full) begin
                nib   <= '0;
                mem_a <= addr;
                mem_d <= word_next;
              end else begin
                nib <= nib + 1'b1;
              end
              word_buf <= word_next;
            end else begin
              if (nib != '0) partial <= 1'b1;
              nib <= '0;
            end
          end
          if (pend_valid) begin
            pend_valid <= uart_ready;
            if (uart_ready) pend_data <= uart_data;
          end
        end
        S_WRITE: begin
          if (uart_ready) begin
            if (pend_valid) begin
              overrun <= 1'b1;
            end else begin
              pend_valid <= 1'b1;
              pend_data  <= uart_data;
            end
          end
          if (mem_ready) begin
            addr  <= addr + ADDR_STEP;
            words <= words + 32'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    spo = 32'h0;
    case (a)
      3'd0:    spo = base_rd;
      3'd2:    spo = words;
      3'd3:    spo = {29'h0, partial, overrun, busy};
      default: spo = 32'h0;
    endcase
  end

endmodule
